// File: rtl/ack_bus_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ack_bus_rx : shared ack bus receiver, outstanding-request matching,         |
// | completion FIFO and sticky errors. Optional watchdog: ACK_RX_TIMEOUT_EN.    |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module ack_bus_rx #(
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ack_valid_n_bus_i,
   input  logic [1:0] ack_id_bus_i,
   input  logic       issue_valid,
   input  logic [1:0] issue_id,
   output logic       cpl_valid,
   output logic [1:0] cpl_id,
   input  logic       cpl_ready,
   output logic       outstanding_any,
   output logic       unexpected_ack,
   output logic       overflow,
   output logic       timeout_err,
   input  logic       err_clr
);
   localparam int               c_aw      = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic              r_ack_q;
   logic [1:0]        r_id_q;
   logic [CNT_W-1:0]  r_cnt [4];
   logic [1:0]        r_fifo [FIFO_DEPTH];
   logic [c_aw:0]     r_wr_ptr;
   logic [c_aw:0]     r_rd_ptr;
   logic              r_unexp;
   logic              r_ovf;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_cnt_zero;
   logic              w_rej;
   logic              w_drop;
   logic              w_accept;
   logic [3:0]        w_inc;
   logic [3:0]        w_dec;
   logic              w_sat;
   logic              w_any;
   logic              w_tmo;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign w_pop      = ~w_empty & cpl_ready;
   assign w_cnt_zero = (r_cnt[r_id_q] == '0);
   assign w_rej      = r_ack_q & w_cnt_zero;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_drop     = r_ack_q & ~w_cnt_zero & w_full & ~w_pop;
   assign w_accept   = r_ack_q & ~w_cnt_zero & ~(w_full & ~w_pop);

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      w_sat = 1'b0;
      w_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_inc[i] = issue_valid && (issue_id == 2'(i));
         w_dec[i] = w_accept && (r_id_q == 2'(i));
         if (w_inc[i] && !w_dec[i] && (r_cnt[i] == c_cnt_max))
            w_sat = 1'b1;
         if (r_cnt[i] != '0)
            w_any = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ack_q  <= 1'b0;
         r_id_q   <= 2'd0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_unexp  <= 1'b0;
         r_ovf    <= 1'b0;
         for (int i = 0; i < 4; i++)
            r_cnt[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_fifo[i] <= 2'd0;
      end else begin
         r_ack_q <= ~ack_valid_n_bus_i;
         r_id_q  <= ack_id_bus_i;
         // Issue and accepted ack on the same source cancel out.
         for (int i = 0; i < 4; i++) begin
            if (w_inc[i] && !w_dec[i] && (r_cnt[i] != c_cnt_max))
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            else if (w_dec[i] && !w_inc[i])
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
         end
         if (w_accept) begin
            r_fifo[r_wr_ptr[c_aw-1:0]] <= r_id_q;
            r_wr_ptr                   <= r_wr_ptr + (c_aw+1)'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
         r_unexp <= (r_unexp & ~err_clr) | w_rej;
         r_ovf   <= (r_ovf & ~err_clr) | w_drop | w_sat;
      end
   end

`ifdef ACK_RX_TIMEOUT_EN
   localparam logic [15:0] c_tmo = 16'(TIMEOUT_CYCLES);

   logic [15:0] r_wdog;
   logic        r_tmo;

   // Watchdog parks at the threshold so the error re-arms after err_clr.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wdog <= 16'd0;
         r_tmo  <= 1'b0;
      end else begin
         if (w_accept || !w_any)
            r_wdog <= 16'd0;
         else if (r_wdog != c_tmo)
            r_wdog <= r_wdog + 16'd1;
         r_tmo <= (r_tmo & ~err_clr) | (r_wdog == c_tmo);
      end
   end

   assign w_tmo = r_tmo;
`else
   assign w_tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   assign cpl_valid       = ~w_empty;
   assign cpl_id          = r_fifo[r_rd_ptr[c_aw-1:0]];
   assign outstanding_any = w_any;
   assign unexpected_ack  = r_unexp;
   assign overflow        = r_ovf;
   assign timeout_err     = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_ack_bus_rx.sv
`default_nettype none
// tb_ack_bus_rx : directed scenarios plus randomized traffic against a queue-based
// reference model of the ack receiver.
module tb_ack_bus_rx;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int TMO   = 10;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef ACK_RX_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, bus_n, issue_valid, cpl_ready, err_clr;
   logic [1:0] bus_id, issue_id;
   logic       cpl_valid, outstanding_any, unexpected_ack, overflow, timeout_err;
   logic [1:0] cpl_id;

   always #5 clk = ~clk;

   ack_bus_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ack_valid_n_bus_i(bus_n), .ack_id_bus_i(bus_id),
      .issue_valid(issue_valid), .issue_id(issue_id),
      .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_ready(cpl_ready),
      .outstanding_any(outstanding_any), .unexpected_ack(unexpected_ack),
      .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the receiver should hold after each clock edge.
   bit m_ok = 1'b0;
   bit m_ack_q;
   int m_id_q;
   int m_cnt [4];
   int m_q [$];
   bit m_unexp, m_ovf, m_tmo;
   int m_wdog;

   function automatic bit m_any();
      return (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) != 0;
   endfunction

   task automatic model_edge();
      bit pop, acc, su, so, st;
      if (!rst_n) begin
         m_ack_q = 1'b0; m_id_q = 0; m_cnt = '{default: 0}; m_q.delete();
         m_unexp = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_wdog = 0; m_ok = 1'b1;
         return;
      end
      pop = (m_q.size() != 0) && cpl_ready;
      acc = 1'b0; su = 1'b0; so = 1'b0; st = 1'b0;
      if (m_ack_q) begin
         if (m_cnt[m_id_q] == 0)                 su  = 1'b1;
         else if (m_q.size() == DEPTH && !pop)   so  = 1'b1;
         else                                    acc = 1'b1;
      end
      if (TMO_EN) begin
         st = (m_wdog == TMO);
         if (acc || !m_any()) m_wdog = 0;
         else if (m_wdog < TMO) m_wdog++;
      end
      if (issue_valid && !(acc && m_id_q == int'(issue_id))) begin
         if (m_cnt[issue_id] == CMAX) so = 1'b1;
         else m_cnt[issue_id]++;
      end
      if (acc && !(issue_valid && m_id_q == int'(issue_id))) m_cnt[m_id_q]--;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(m_id_q);
      m_unexp = (m_unexp && !err_clr) || su;
      m_ovf   = (m_ovf && !err_clr) || so;
      m_tmo   = (m_tmo && !err_clr) || st;
      m_ack_q = !bus_n;
      m_id_q  = int'(bus_id);
   endtask

   task automatic tick();
      @(negedge clk);
      if (m_ok) begin
         check("cpl_valid", cpl_valid, m_q.size() != 0);
         if (m_q.size() != 0) check("cpl_id", cpl_id, m_q[0]);
         check("outstanding_any", outstanding_any, m_any());
         check("unexpected_ack", unexpected_ack, m_unexp);
         check("overflow", overflow, m_ovf);
         check("timeout_err", timeout_err, m_tmo);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1; bus_n = 1'b1; issue_valid = 1'b0; cpl_ready = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      idle();
   endtask

   int seq3 [5] = '{0, 1, 3, 0, 2};
   int exp4 [4] = '{1, 3, 0, 2};

   initial begin
      idle(); bus_id = 2'd0; issue_id = 2'd0;
      rst_n = 1'b0;
      tick();
      tick();
      idle();
      check("rst_cpl_valid", cpl_valid, 0);
      check("rst_cpl_id", cpl_id, 0);
      check("rst_outstanding", outstanding_any, 0);
      check("rst_unexp", unexpected_ack, 0);
      check("rst_ovf", overflow, 0);
      check("rst_tmo", timeout_err, 0);

      // Single issue/ack round trip with fixed latency.
      issue_valid = 1'b1; issue_id = 2'd2; tick(); idle();
      tick(); tick();
      bus_n = 1'b0; bus_id = 2'd2; tick(); idle();
      tick();
      check("t1_valid", cpl_valid, 1);
      check("t1_id", cpl_id, 2);
      cpl_ready = 1'b1; tick(); idle();
      check("t1_empty", cpl_valid, 0);
      check("t1_outst", outstanding_any, 0);

      // Unexpected ack, then clear.
      bus_n = 1'b0; bus_id = 2'd1; tick(); idle();
      tick();
      check("t2_unexp", unexpected_ack, 1);
      check("t2_nopush", cpl_valid, 0);
      err_clr = 1'b1; tick(); idle();
      check("t2_clr", unexpected_ack, 0);

      // Fill FIFO, fifth ack dropped.
      for (int k = 0; k < 5; k++) begin
         issue_valid = 1'b1; issue_id = 2'(seq3[k]); tick(); idle();
      end
      for (int k = 0; k < 5; k++) begin
         bus_n = 1'b0; bus_id = 2'(seq3[k]); tick(); idle();
      end
      tick(); tick();
      check("t3_ovf", overflow, 1);
      check("t3_outst", outstanding_any, 1);
      check("t3_valid", cpl_valid, 1);
      check("t3_head", cpl_id, 0);

      // Full FIFO: simultaneous pop and push.
      err_clr = 1'b1; tick(); idle();
      check("t4_ovf_clr", overflow, 0);
      bus_n = 1'b0; bus_id = 2'd2; tick(); idle();
      cpl_ready = 1'b1; tick(); idle();
      tick();
      check("t4_ovf", overflow, 0);
      for (int k = 0; k < 4; k++) begin
         check("t4_order", cpl_id, exp4[k]);
         check("t4_valid", cpl_valid, 1);
         cpl_ready = 1'b1; tick(); idle();
      end
      check("t4_empty", cpl_valid, 0);
      check("t4_outst", outstanding_any, 0);

      // Counter saturation.
      for (int k = 0; k < 8; k++) begin
         issue_valid = 1'b1; issue_id = 2'd3; tick(); idle();
      end
      check("t5_ovf", overflow, 1);
      check("t5_outst", outstanding_any, 1);

      // Watchdog.
      do_reset();
      issue_valid = 1'b1; issue_id = 2'd0; tick(); idle();
      for (int k = 0; k < 10; k++) tick();
      check("t6_tmo_early", timeout_err, 0);
      tick();
      check("t6_tmo", timeout_err, TMO_EN ? 1 : 0);
      err_clr = 1'b1; tick(); idle();
      check("t6_tmo_rearm", timeout_err, TMO_EN ? 1 : 0);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst_n       = ($urandom_range(0, 299) != 0);
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_id    = 2'($urandom_range(0, 3));
         bus_n       = ($urandom_range(0, 9) >= 4);
         bus_id      = 2'($urandom_range(0, 3));
         cpl_ready   = ($urandom_range(0, 2) != 0);
         err_clr     = ($urandom_range(0, 19) == 0);
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ack_bus_rx.md
# ack_bus_rx

Receiving end of the shared acknowledge bus: samples the active-low ack valid strobe and 2-bit source ID driven by the ack bus arbiter, and checks each ack against per-source outstanding-request counters maintained by the controller. Matched acks are queued in a small completion FIFO for the controller to pop with a valid/ready handshake. Protocol violations are latched as sticky error flags: unexpected ack, counter/FIFO overflow and, optionally, a watchdog timeout.

## Interface
Parameters:
- FIFO_DEPTH, 4, completion FIFO entries; power of two, ≥2
- CNT_W, 3, width of each per-source outstanding counter
- TIMEOUT_CYCLES, 255, idle cycles with work outstanding before timeout_err; only used with ACK_RX_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ack_valid_n_bus_i  in  1  bus ack strobe, active low, one ack per low cycle
- ack_id_bus_i  in  2  source ID of ack: 0 mem, 1 sha, 2 aes, 3 ctrl
- issue_valid  in  1  controller issued a request to source issue_id this cycle
- issue_id  in  2  target source of issued request
- cpl_valid  out  1  completion FIFO non-empty
- cpl_id  out  2  source ID at FIFO head
- cpl_ready  in  1  controller pops head when cpl_valid & cpl_ready
- outstanding_any  out  1  any per-source counter non-zero
- unexpected_ack  out  1  sticky: ack for source with zero outstanding
- overflow  out  1  sticky: counter saturation or FIFO-full drop
- timeout_err  out  1  sticky watchdog error; constant 0 without ACK_RX_TIMEOUT_EN
- err_clr  in  1  clears all sticky flags

## Operation
- Input stage: ack_valid_n_bus_i and ack_id_bus_i registered once every cycle into ack_q (active-high) / id_q. Reset: ack_q=0.
- Accept stage, acting on ack_q, id_q:
  - cnt[id_q]==0: ack rejected; unexpected_ack set; counter unchanged; no push.
  - FIFO full and no pop this cycle: ack dropped; overflow set; counter unchanged.
  - otherwise: accepted; cnt[id_q] decrements; id_q pushed.
- Issue: issue_valid increments cnt[issue_id]. At all-ones it saturates and sets overflow.
- Issue and accepted ack to the same ID in one cycle: counter unchanged, no error. Counter at 0 plus issue plus ack on same ID: ack rejected with unexpected_ack, counter becomes 1.
- FIFO: circular, read/write pointers one bit wider than log2(FIFO_DEPTH); full/empty from MSB compare; pointers wrap naturally. Simultaneous push and pop when full: both succeed, count unchanged. Push into empty FIFO does not fall through: cpl_valid rises the following cycle.
- cpl_id holds the head entry whenever cpl_valid=1. Value undefined-but-stable (registered) when empty.
- Sticky flags: set by an event, cleared by err_clr. If err_clr and a set event occur in the same cycle, set wins.
- outstanding_any is the OR of all counters (registered counters, combinational OR).

## Timing
- Reset (rst_n low at a rising edge): all counters 0, FIFO empty, ack_q=0, all sticky flags 0, watchdog 0. Outputs after reset: cpl_valid=0, cpl_id=0, outstanding_any=0, unexpected_ack=0, overflow=0, timeout_err=0. Reset mid-operation discards queued completions and counts.
- Ack latency: bus low in cycle N is captured at edge N+1 and pushed at edge N+2. cpl_valid=1 during cycle N+2 at earliest.
- Back-to-back low cycles are distinct acks; throughput is one ack per cycle.
- Issue to counter: issue_valid in cycle N is visible in cnt and outstanding_any from cycle N+1. An ack must reach the accept stage no earlier than cycle N+1 to match it.
- Error flags are visible the cycle after the causing event.

## Configuration
- ACK_RX_TIMEOUT_EN defined: a 16-bit watchdog counter is compiled in.
  - Clears to 0 on an accepted ack, or when outstanding_any=0.
  - Otherwise increments, saturating.
  - When it equals TIMEOUT_CYCLES, timeout_err is set.
  - err_clr clears timeout_err but not the watchdog. The watchdog holds at TIMEOUT_CYCLES, so timeout_err re-sets next cycle if the condition persists.
- ACK_RX_TIMEOUT_EN undefined: no watchdog logic; timeout_err tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Reset, then issue id 2 in cycle 0 and drive bus low with id 2 in cycle 3 -> cpl_valid=1, cpl_id=2 in cycle 5; pop with cpl_ready -> cpl_valid=0 in cycle 6, outstanding_any=0.
- Bus ack id 1 with no issue -> unexpected_ack=1 two cycles later, no FIFO push; err_clr -> flag 0 next cycle.
- Issue ids 0,1,3,0,2 (5 issues), then 5 back-to-back acks with cpl_ready=0 and FIFO_DEPTH=4 -> 4 entries in order 0,1,3,0; fifth dropped; overflow=1; cnt[2] stays 1.
- FIFO full with cpl_ready=1 and an ack arriving the same cycle -> pop and push both succeed, occupancy stays 4, overflow stays 0.
- Issue id 3 seven times then once more (CNT_W=3) -> cnt saturates at 7, overflow=1.
- With ACK_RX_TIMEOUT_EN and TIMEOUT_CYCLES=10: issue id 0, no ack -> timeout_err=1 on the cycle after the watchdog reaches 10. Without the macro -> timeout_err stays 0.
